apb_slave_responder: RTL and testbench

APB3 responder (peripheral end) that the AHB-to-APB bridge's APB controller drives via one `pselx` bit. Implements a word-addressed register file with a programmable wait-state count, error response on bad accesses, a read-only ID word and a completed-write counter. Serves as both a real peripheral template and the bridge's closed-loop verification target.

---
 rtl/apb_pkg.sv | 22 ++
 rtl/apb_regfile.sv | 40 ++++
 rtl/apb_slave_responder.sv | 103 ++++++++++
 tb/tb_apb_slave_responder.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared types and constants for the APB responder and its register file.
package apb_pkg;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } apb_state_e;

  // Bit positions in the error-cause vector; any set bit raises pslverr.
  localparam int ERR_MISALIGN = 0;
  localparam int ERR_RANGE    = 1;
  localparam int ERR_RO_WRITE = 2;
  localparam int ERR_W        = 3;

  localparam logic [31:0] DEFAULT_ID_VALUE = 32'hA5B0_0001;

  // Width of a register index for n words.
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/apb_regfile.sv
// Word register file with a completed-write counter and read-only overlays
// for the ID word (index 0) and the counter word (index NUM_REGS-1).
module apb_regfile
  import apb_pkg::*;
#(
  parameter int          NUM_REGS = 16,
  parameter int          IW       = 4,
  parameter logic [31:0] ID_VALUE = DEFAULT_ID_VALUE
) (
  input  logic          hclk,
  input  logic          hresetn,
  input  logic          wr_en,
  input  logic [IW-1:0] wr_idx,
  input  logic [31:0]   wr_data,
  input  logic [IW-1:0] rd_idx,
  output logic [31:0]   rd_data
);

  logic [31:0] regs [NUM_REGS];
  logic [31:0] wr_count;

  // Storage and write counter; the counter advances only on committed writes.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      wr_count <= '0;
    end else if (wr_en) begin
      regs[wr_idx] <= wr_data;
      wr_count     <= wr_count + 32'd1;
    end
  end

  // Combinational read with ID and counter overlays.
  always_comb begin
    rd_data = regs[rd_idx];
    if (rd_idx == '0)                  rd_data = ID_VALUE;
    else if (rd_idx == IW'(NUM_REGS-1)) rd_data = wr_count;
  end

endmodule

// File: rtl/apb_slave_responder.sv
// APB3 peripheral responder: setup/access FSM with programmable wait states,
// address decode and error response in front of apb_regfile.
module apb_slave_responder
  import apb_pkg::*;
#(
  parameter int          NUM_REGS    = 16,
  parameter int          WAIT_STATES = 1,
  parameter logic [31:0] ID_VALUE    = DEFAULT_ID_VALUE
) (
  input  logic        hclk,
  input  logic        hresetn,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [31:0] paddr,
  input  logic [31:0] pwdata,
  output logic [31:0] prdata,
  output logic        pready,
  output logic        pslverr
);

  localparam int         IW      = idx_width(NUM_REGS);
  localparam logic [3:0] WS_LOAD = 4'(WAIT_STATES);

  apb_state_e   state;
  logic [3:0]   wait_cnt;
  logic [9:0]   idx;
  logic [1:0]   lo_bits;
  logic         wr;
  logic [31:0]  wdata;
  logic [ERR_W-1:0] err_vec;
  logic         err;
  logic         we;
  logic [31:0]  rd_data;
  logic         unused_paddr;

  // Only paddr[11:0] is decoded.
  assign unused_paddr = ^paddr[31:12];

  // Setup latches the transfer; access phase counts down wait states and
  // returns to idle on completion or on a protocol abort.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state    <= ST_IDLE;
      wait_cnt <= '0;
      idx      <= '0;
      lo_bits  <= '0;
      wr       <= 1'b0;
      wdata    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (psel && !penable) begin
            idx      <= paddr[11:2];
            lo_bits  <= paddr[1:0];
            wr       <= pwrite;
            wdata    <= pwdata;
            wait_cnt <= WS_LOAD;
            state    <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (psel && penable) begin
            if (wait_cnt != '0) wait_cnt <= wait_cnt - 4'd1;
            else                state    <= ST_IDLE;
          end else begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Error decode on the latched transfer.
  always_comb begin
    err_vec               = '0;
    err_vec[ERR_MISALIGN] = (lo_bits != 2'b00);
    err_vec[ERR_RANGE]    = (idx >= 10'(NUM_REGS));
    err_vec[ERR_RO_WRITE] = wr && ((idx == 10'd0) || (idx == 10'(NUM_REGS-1)));
  end

  assign err     = |err_vec;
  assign pready  = (state == ST_ACCESS) && psel && penable && (wait_cnt == '0);
  assign pslverr = pready && err;
  assign we      = pready && wr && !err;
  assign prdata  = (pready && !wr && !err) ? rd_data : 32'd0;

  apb_regfile #(
    .NUM_REGS (NUM_REGS),
    .IW       (IW),
    .ID_VALUE (ID_VALUE)
  ) u_regfile (
    .hclk    (hclk),
    .hresetn (hresetn),
    .wr_en   (we),
    .wr_idx  (idx[IW-1:0]),
    .wr_data (wdata),
    .rd_idx  (idx[IW-1:0]),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_apb_slave_responder.sv
// Bench for apb_slave_responder: one instance with one wait state, one with
// zero wait states, directed scenarios followed by random transfers.
module tb_apb_slave_responder;

  localparam logic [31:0] ID = 32'hA5B0_0001;
  localparam int NREG = 16;

  logic        hclk = 1'b0;
  logic        hresetn = 1'b0;
  logic        psel_a = 1'b0, psel_b = 1'b0;
  logic        penable = 1'b0, pwrite = 1'b0;
  logic [31:0] paddr = '0, pwdata = '0;
  logic [31:0] prdata_a, prdata_b;
  logic        pready_a, pready_b, pslverr_a, pslverr_b;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem  [2][NREG];
  logic [31:0] wcnt [2];
  int          ws   [2];

  always #5 hclk = ~hclk;

  apb_slave_responder #(.NUM_REGS(NREG), .WAIT_STATES(1), .ID_VALUE(ID)) dut_a (
    .hclk(hclk), .hresetn(hresetn), .psel(psel_a), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata_a), .pready(pready_a), .pslverr(pslverr_a));

  apb_slave_responder #(.NUM_REGS(NREG), .WAIT_STATES(0), .ID_VALUE(ID)) dut_b (
    .hclk(hclk), .hresetn(hresetn), .psel(psel_b), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata_b), .pready(pready_b), .pslverr(pslverr_b));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rd(input int s);
    return (s == 0) ? prdata_a : prdata_b;
  endfunction
  function automatic logic rdy(input int s);
    return (s == 0) ? pready_a : pready_b;
  endfunction
  function automatic logic serr(input int s);
    return (s == 0) ? pslverr_a : pslverr_b;
  endfunction

  task automatic model_reset();
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < NREG; i++) mem[s][i] = '0;
      wcnt[s] = '0;
    end
  endtask

  task automatic set_sel(input int s, input logic v);
    if (s == 0) psel_a = v; else psel_b = v;
  endtask

  task automatic bus_idle();
    @(posedge hclk); #1;
    psel_a = 1'b0; psel_b = 1'b0; penable = 1'b0;
  endtask

  // One complete transfer, checked against the reference model. Leaves the
  // bus in the completed access phase so a following call is back-to-back.
  task automatic xfer(input int s, input logic w, input logic [31:0] addr,
                      input logic [31:0] data, input string tag);
    int  cyc;
    bit  done;
    int  index;
    bit  exp_err;
    logic [31:0] exp_rd;
    index   = int'(addr[11:2]);
    exp_err = (addr[1:0] != 2'b00) || (index >= NREG) ||
              (w && (index == 0 || index == NREG-1));
    if (w || exp_err)         exp_rd = 32'd0;
    else if (index == 0)      exp_rd = ID;
    else if (index == NREG-1) exp_rd = wcnt[s];
    else                      exp_rd = mem[s][index];

    @(posedge hclk); #1;
    set_sel(s, 1'b1); set_sel(1 - s, 1'b0);
    penable = 1'b0; pwrite = w; paddr = addr; pwdata = data;
    cyc = 1;
    @(posedge hclk); #1;
    penable = 1'b1;
    done = 0;
    for (int i = 0; i < 32 && !done; i++) begin
      cyc++;
      @(negedge hclk);
      if (rdy(s)) done = 1;
      else begin
        check({tag, ".wait_prdata"}, rd(s), 32'd0);
        check({tag, ".wait_pslverr"}, {31'd0, serr(s)}, 32'd0);
        @(posedge hclk); #1;
      end
    end
    check({tag, ".completed"}, {31'd0, done}, 32'd1);
    if (done) begin
      check({tag, ".cycles"}, cyc, ws[s] + 2);
      check({tag, ".pslverr"}, {31'd0, serr(s)}, {31'd0, exp_err});
      if (!w) check({tag, ".prdata"}, rd(s), exp_rd);
      if (w && !exp_err) begin
        mem[s][index] = data;
        wcnt[s] = wcnt[s] + 32'd1;
      end
    end
  endtask

  initial begin
    ws[0] = 1; ws[1] = 0;
    model_reset();

    #1;
    check("reset.pready_a", {31'd0, pready_a}, 32'd0);
    check("reset.prdata_a", prdata_a, 32'd0);
    check("reset.pslverr_b", {31'd0, pslverr_b}, 32'd0);
    repeat (2) @(posedge hclk);
    #1 hresetn = 1'b1;

    xfer(0, 0, 32'h000, 0, "id_read");
    xfer(0, 1, 32'h004, 32'hDEADBEEF, "wr4");
    xfer(0, 0, 32'h004, 0, "rd4");
    xfer(0, 0, 32'h03C, 0, "cnt1");
    check("cnt1.model", wcnt[0], 32'd1);
    xfer(0, 1, 32'h008, 32'd1, "b2b_wr8");
    xfer(0, 1, 32'h00C, 32'd2, "b2b_wrC");
    xfer(0, 0, 32'h008, 0, "rd8");
    xfer(0, 0, 32'h00C, 0, "rdC");
    xfer(0, 0, 32'h03C, 0, "cnt2");
    xfer(0, 1, 32'h000, 32'h1234, "err_wr_id");
    xfer(0, 1, 32'h041, 32'h5678, "err_misalign");
    xfer(0, 0, 32'h040, 0, "err_range_rd");
    xfer(0, 1, 32'h03C, 32'h9, "err_wr_cnt");
    xfer(0, 0, 32'h03C, 0, "cnt_after_err");
    bus_idle();

    // Abort: drop psel during the wait cycle of a write to index 4.
    @(posedge hclk); #1;
    psel_a = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h010; pwdata = 32'd5;
    @(posedge hclk); #1;
    penable = 1'b1;
    @(negedge hclk);
    check("abort.wait_pready", {31'd0, pready_a}, 32'd0);
    @(posedge hclk); #1;
    psel_a = 1'b0; penable = 1'b0;
    @(negedge hclk);
    check("abort.pready", {31'd0, pready_a}, 32'd0);
    xfer(0, 0, 32'h010, 0, "abort.rd10");
    xfer(0, 0, 32'h03C, 0, "abort.cnt");
    bus_idle();

    xfer(1, 1, 32'h010, 32'h0000_0077, "ws0.wr10");
    xfer(1, 0, 32'h010, 0, "ws0.rd10");
    bus_idle();

    for (int n = 0; n < 60; n++) begin
      int s, idx, lo;
      logic [31:0] a;
      s   = int'($urandom_range(0, 1));
      idx = int'($urandom_range(0, 18));
      lo  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 0;
      a   = $urandom;
      a[11:0] = {idx[9:0], lo[1:0]};
      xfer(s, 1'($urandom_range(0, 1)), a, $urandom, "rand");
      if ($urandom_range(0, 3) == 0) bus_idle();
    end
    bus_idle();

    // Reset during the completing access phase of a zero-wait read.
    xfer(1, 1, 32'h014, 32'hCAFE_F00D, "rst.pre_wr");
    @(posedge hclk); #1;
    psel_b = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h014;
    @(posedge hclk); #1;
    penable = 1'b1;
    #2;
    check("rst.pre_pready", {31'd0, pready_b}, 32'd1);
    check("rst.pre_prdata", prdata_b, 32'hCAFE_F00D);
    hresetn = 1'b0;
    #1;
    check("rst.pready", {31'd0, pready_b}, 32'd0);
    check("rst.prdata", prdata_b, 32'd0);
    check("rst.pslverr", {31'd0, pslverr_b}, 32'd0);
    model_reset();
    @(posedge hclk); #1;
    psel_b = 1'b0; penable = 1'b0;
    hresetn = 1'b1;
    xfer(1, 0, 32'h014, 0, "post_rst.rd14");
    xfer(1, 0, 32'h03C, 0, "post_rst.cnt_b");
    xfer(0, 0, 32'h004, 0, "post_rst.rd4_a");
    xfer(0, 0, 32'h03C, 0, "post_rst.cnt_a");
    xfer(0, 1, 32'h018, 32'h0BAD_CAFE, "post_rst.wr18");
    xfer(0, 0, 32'h018, 0, "post_rst.rd18");
    bus_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
